// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle memory front end for the multi-cycle RISC-V core.
// Accepts one read/write request from the control unit, waits a fixed latency
// against a unified word-addressed instruction/data array, then commits the
// result into IR, MDR or the array and pulses ready for one cycle.
module mem_access_unit #(
    parameter int MEM_WORDS = 16384,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        ir_write,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        ready,
    output logic        stall,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic        err
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      din_q, din_d;
    logic             wr_q, wr_d;       // latched op: 1 = write (also when both strobes high)
    logic             irw_q, irw_d;     // latched fetch qualifier
    logic             mis_q, mis_d;     // latched misalignment
    logic             fault_q, fault_d; // err value to present at ready
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      mdr_q, mdr_d;

    // Unified instruction/data array; no reset, contents come from writes only.
    logic [31:0]      mem [MEM_WORDS];
    logic [31:0]      rd_word_q;
    logic             commit_wr;
    logic [31:0]      rd_val;

    // Address bits above the word index are intentionally ignored (wrap-around).
    logic             unused_addr_bits;
    assign unused_addr_bits = ^addr[31:IDX_W+2];

    // Completion is a pure decode of registered state, so ready/err never see inputs.
    assign ready     = (state_q == BUSY) && (cnt_q == 4'd0);
    assign err       = ready & fault_q;
    assign stall     = (mem_read | mem_write) & ~ready;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign commit_wr = ready & wr_q & ~mis_q & ~reset;

    // Next-state logic: accept in IDLE, count down in BUSY, commit when the count hits zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        din_d   = din_q;
        wr_d    = wr_q;
        irw_d   = irw_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        rd_val  = mis_q ? 32'd0 : rd_word_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    idx_d   = addr[IDX_W+1:2];
                    din_d   = din;
                    wr_d    = mem_write;
                    irw_d   = ir_write & ~mem_write;
                    mis_d   = (addr[1:0] != 2'b00);
                    fault_d = (mem_read & mem_write) | (addr[1:0] != 2'b00);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (!wr_q) begin
                        if (irw_q) begin
                            ir_d = rd_val;
                        end else begin
                            mdr_d = rd_val;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            din_q   <= 32'd0;
            wr_q    <= 1'b0;
            irw_q   <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            ir_q    <= 32'd0;
            mdr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            irw_q   <= irw_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
        end
    end

    // Array port: the read is addressed with the next index so the word is ready
    // by the completion cycle even at LATENCY=1; a write commits on the ready edge.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[idx_q] <= din_q;
        end
        rd_word_q <= mem[idx_d];
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: two instances (LATENCY=3 and LATENCY=1) driven
// by a control-unit-like request task; expected results come from a small
// reference model and are queued at request time, then popped at ready.
module tb_mem_access_unit;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [1:0]  irw;
    logic [31:0] ad [2];
    logic [31:0] dn [2];
    logic [1:0]  rdy;
    logic [1:0]  stl;
    logic [1:0]  er;
    logic [31:0] irv [2];
    logic [31:0] mdv [2];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] ir;
        logic [31:0] mdr;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model_mem [int];
    logic [31:0] m_ir  [2];
    logic [31:0] m_mdr [2];

    mem_access_unit #(.MEM_WORDS(16384), .LATENCY(3)) u_lat3 (
        .clk       (clk),
        .reset     (rst[0]),
        .mem_read  (rd[0]),
        .mem_write (wr[0]),
        .ir_write  (irw[0]),
        .addr      (ad[0]),
        .din       (dn[0]),
        .ready     (rdy[0]),
        .stall     (stl[0]),
        .ir        (irv[0]),
        .mdr       (mdv[0]),
        .err       (er[0])
    );

    mem_access_unit #(.MEM_WORDS(16384), .LATENCY(1)) u_lat1 (
        .clk       (clk),
        .reset     (rst[1]),
        .mem_read  (rd[1]),
        .mem_write (wr[1]),
        .ir_write  (irw[1]),
        .addr      (ad[1]),
        .din       (dn[1]),
        .ready     (rdy[1]),
        .stall     (stl[1]),
        .ir        (irv[1]),
        .mdr       (mdv[1]),
        .err       (er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, got, exp);
    endtask

    // One access as the control unit would issue it: hold the request until ready.
    task automatic access(input int s, input bit r, input bit w, input bit i,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        exp_t        e;
        exp_t        got_e;
        int          key;
        int          k;
        bit          stall_ok;
        logic [31:0] rv;
        // reference model
        e.lat = (s == 0) ? 3 : 1;
        e.err = (r & w) | (a[1:0] != 2'b00);
        key   = s * 65536 + int'(a[15:2]);
        if (w) begin
            if (a[1:0] == 2'b00) model_mem[key] = d;
        end else begin
            rv = 32'd0;
            if (a[1:0] == 2'b00 && model_mem.exists(key)) rv = model_mem[key];
            if (i) m_ir[s] = rv;
            else   m_mdr[s] = rv;
        end
        e.ir  = m_ir[s];
        e.mdr = m_mdr[s];
        sb.push_back(e);

        @(posedge clk); #1;
        rd[s] = r; wr[s] = w; irw[s] = i; ad[s] = a; dn[s] = d;
        stall_ok = 1'b1;
        k = 0;
        while (k <= 20) begin
            @(negedge clk);
            if (rdy[s]) break;
            if (!stl[s]) stall_ok = 1'b0;
            k++;
        end
        got_e = sb.pop_front();
        check({tag, "_latency"}, 32'(k), 32'(got_e.lat));
        check({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
        check({tag, "_stall_at_ready"}, {31'd0, stl[s]}, 32'd0);
        check({tag, "_err"}, {31'd0, er[s]}, {31'd0, got_e.err});
        @(posedge clk); #1;
        rd[s] = 1'b0; wr[s] = 1'b0; irw[s] = 1'b0;
        @(negedge clk);
        check({tag, "_ir"}, irv[s], got_e.ir);
        check({tag, "_mdr"}, mdv[s], got_e.mdr);
        $display("txn %s dut%0d rd=%0d wr=%0d irw=%0d addr=%h din=%h lat=%0d err=%0d ir=%h mdr=%h",
                 tag, s, r, w, i, a, d, k, er[s], irv[s], mdv[s]);
    endtask

    initial begin
        logic [5:0] pattern;
        bit         saw_rdy;

        rst = 2'b11; rd = '0; wr = '0; irw = '0;
        for (int s = 0; s < 2; s++) begin
            ad[s] = 32'd0; dn[s] = 32'd0; m_ir[s] = 32'd0; m_mdr[s] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        check("rst_ready", {31'd0, rdy[0]}, 32'd0);
        check("rst_stall", {31'd0, stl[0]}, 32'd0);
        check("rst_err",   {31'd0, er[0]},  32'd0);
        check("rst_ir",    irv[0], 32'd0);
        check("rst_mdr",   mdv[0], 32'd0);
        check("rst_ir_l1", irv[1], 32'd0);

        // LATENCY=3 instance
        access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0050_0093, "preload_fetch_word");
        access(0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         "fetch");
        access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, "store");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,         "load");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0001_0200, 32'h0,         "load_wrap");
        access(0, 1'b0, 1'b1, 1'b1, 32'h0000_0202, 32'h1234_5678, "store_misaligned");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,         "load_after_misaligned");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0201, 32'h0,         "load_misaligned");
        access(0, 1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_0001, "store_irw_ignored");
        access(0, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0,         "fetch_after_store");
        access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h1111_2222, "preload_abort_word");

        // Reset mid-access: write to 0x40 aborted one cycle after acceptance.
        saw_rdy = 1'b0;
        @(posedge clk); #1;
        wr[0] = 1'b1; ad[0] = 32'h0000_0040; dn[0] = 32'h3333_4444;
        @(negedge clk); saw_rdy |= rdy[0];
        @(posedge clk); #1;
        rst[0] = 1'b1; wr[0] = 1'b0;
        @(negedge clk); saw_rdy |= rdy[0];
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk); saw_rdy |= rdy[0];
        check("abort_ir",    irv[0], 32'd0);
        check("abort_mdr",   mdv[0], 32'd0);
        check("abort_stall", {31'd0, stl[0]}, 32'd0);
        repeat (4) begin
            @(negedge clk); saw_rdy |= rdy[0];
        end
        check("abort_no_ready", {31'd0, saw_rdy}, 32'd0);
        $display("txn abort dut0 addr=00000040 ready_seen=%0d ir=%h mdr=%h", saw_rdy, irv[0], mdv[0]);
        m_ir[0] = 32'd0; m_mdr[0] = 32'd0;
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, "load_after_abort");

        // LATENCY=1 instance
        access(1, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, "l1_store");
        @(posedge clk); #1;
        rd[1] = 1'b1; irw[1] = 1'b0; ad[1] = 32'h0000_0010;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            pattern[j] = rdy[1];
        end
        @(posedge clk); #1;
        rd[1] = 1'b0;
        @(negedge clk);
        m_mdr[1] = 32'hCAFE_F00D;
        check("b2b_pattern", {26'd0, pattern}, 32'h0000_002A);
        check("b2b_pulses",  32'($countones(pattern)), 32'd3);
        check("b2b_mdr",     mdv[1], m_mdr[1]);
        $display("txn b2b dut1 addr=00000010 ready_pattern=%b mdr=%h", pattern, mdv[1]);
        access(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, "l1_read_and_write");
        access(1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         "l1_load_after_both");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
